// File: rtl/alu_pkg.sv
// Shared types and constants for the calculator control, ALU and register-update blocks.
// ALU_CTRL_MUL_EN adds the multiply operation and its controller state.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
`ifdef ALU_CTRL_MUL_EN
    OP_MOD = 3'b010,
    OP_MUL = 3'b011
`else
    OP_MOD = 3'b010
`endif
  } alu_op_t;

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_ADD    = 3'd2,
    S_SUB    = 3'd3,
`ifdef ALU_CTRL_MUL_EN
    S_MOD    = 3'd4,
    S_MUL    = 3'd5
`else
    S_MOD    = 3'd4
`endif
  } ctrl_state_t;

  // reg_ctrl: bit1 = load enable, bit0 = operand select (0 = A, 1 = B)
  localparam logic [1:0] REG_IDLE   = 2'b00;
  localparam logic [1:0] REG_LOAD_A = 2'b10;
  localparam logic [1:0] REG_LOAD_B = 2'b11;

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: SYNC_STAGES-flop synchroniser (>= 2) followed by a rising-edge detector.
// press_o is a single-cycle pulse per press, combinational from the last two flops.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_ctrl.sv
// Calculator sequencer: operand load strobes (A then B), then enter cycles the ALU op; sign toggles mode.
// Outputs registered, two clocks after a button is first sampled high; ALU_CTRL_MUL_EN adds S_MUL.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_i,
  input  logic       sign_i,
  output logic [1:0] reg_ctrl,
  output alu_op_t    alu_op,
  output logic       signed_mode,
  output logic       op_valid
);

  logic press_enter;
  logic press_sign;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (enter_i),
    .press_o (press_enter)
  );

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sign (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (sign_i),
    .press_o (press_sign)
  );

  ctrl_state_t state_q, state_d;
  logic [1:0]  reg_ctrl_q, reg_ctrl_d;
  alu_op_t     alu_op_q, alu_op_d;
  logic        signed_q, signed_d;
  logic        op_valid_q, op_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD_A;
      reg_ctrl_q <= REG_IDLE;
      alu_op_q   <= OP_ADD;
      signed_q   <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_ctrl_q <= reg_ctrl_d;
      alu_op_q   <= alu_op_d;
      signed_q   <= signed_d;
      op_valid_q <= op_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reg_ctrl_d = REG_IDLE;
    alu_op_d   = alu_op_q;
    signed_d   = signed_q ^ press_sign;
    op_valid_d = 1'b0;

    case (state_q)
      S_LOAD_A: if (press_enter) begin
        state_d    = S_LOAD_B;
        reg_ctrl_d = REG_LOAD_A;
      end
      S_LOAD_B: if (press_enter) begin
        state_d    = S_ADD;
        reg_ctrl_d = REG_LOAD_B;
      end
      S_ADD: if (press_enter) state_d = S_SUB;
      S_SUB: if (press_enter) state_d = S_MOD;
`ifdef ALU_CTRL_MUL_EN
      S_MOD: if (press_enter) state_d = S_MUL;
      S_MUL: if (press_enter) state_d = S_ADD;
`else
      S_MOD: if (press_enter) state_d = S_ADD;
`endif
      default: state_d = S_LOAD_A;
    endcase

    // alu_op/op_valid follow the next state so they stay aligned with state_q
    case (state_d)
      S_ADD: begin alu_op_d = OP_ADD; op_valid_d = 1'b1; end
      S_SUB: begin alu_op_d = OP_SUB; op_valid_d = 1'b1; end
      S_MOD: begin alu_op_d = OP_MOD; op_valid_d = 1'b1; end
`ifdef ALU_CTRL_MUL_EN
      S_MUL: begin alu_op_d = OP_MUL; op_valid_d = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign reg_ctrl    = reg_ctrl_q;
  assign alu_op      = alu_op_q;
  assign signed_mode = signed_q;
  assign op_valid    = op_valid_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: behavioural model compared every cycle, plus literal directed checks.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int SYNC = 2;
`ifdef ALU_CTRL_MUL_EN
  localparam int NOPS = 4;
`else
  localparam int NOPS = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter_i = 1'b0;
  logic       sign_i = 1'b0;
  logic [1:0] reg_ctrl;
  alu_op_t    alu_op;
  logic       signed_mode;
  logic       op_valid;

  int tests = 0;
  int fails = 0;

  alu_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .enter_i     (enter_i),
    .sign_i      (sign_i),
    .reg_ctrl    (reg_ctrl),
    .alu_op      (alu_op),
    .signed_mode (signed_mode),
    .op_valid    (op_valid)
  );

  always #5 clk = ~clk;

  // Model: sampled-level history per button, and an operation phase counter
  // (0 = loading A, 1 = loading B, 2.. = operation index + 2).
  bit         eq[$];
  bit         sq[$];
  int         phase;
  logic [1:0] m_reg;
  logic [2:0] m_op;
  logic       m_sgn;

  task automatic model_reset();
    eq = {};
    sq = {};
    for (int i = 0; i <= SYNC; i++) begin
      eq.push_front(1'b0);
      sq.push_front(1'b0);
    end
    phase = 0;
    m_reg = 2'b00;
    m_op  = 3'b000;
    m_sgn = 1'b0;
  endtask

  task automatic model_step();
    bit pe, ps;
    // A press acts at edge n when the level sampled at edge n-SYNC was high and at n-SYNC-1 low.
    pe = eq[SYNC-1] && !eq[SYNC];
    ps = sq[SYNC-1] && !sq[SYNC];
    eq.push_front(enter_i);
    void'(eq.pop_back());
    sq.push_front(sign_i);
    void'(sq.pop_back());
    m_reg = 2'b00;
    if (ps) m_sgn = ~m_sgn;
    if (pe) begin
      if (phase == 0) begin
        phase = 1;
        m_reg = 2'b10;
      end else if (phase == 1) begin
        phase = 2;
        m_reg = 2'b11;
      end else begin
        phase = 2 + ((phase - 1) % NOPS);
      end
    end
    if (phase >= 2) m_op = 3'(phase - 2);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_step();
    #1;
    chk("reg_ctrl", 8'(reg_ctrl), 8'(m_reg));
    chk("alu_op", 8'(alu_op), 8'(m_op));
    chk("signed_mode", 8'(signed_mode), 8'(m_sgn));
    chk("op_valid", 8'(op_valid), 8'(phase >= 2));
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic press_enter(input int hold);
    @(negedge clk);
    enter_i = 1'b1;
    repeat (hold) @(negedge clk);
    enter_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic press_sign(input int hold);
    @(negedge clk);
    sign_i = 1'b1;
    repeat (hold) @(negedge clk);
    sign_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  logic [2:0] op_seq[4];
  bit         seen;

  initial begin
    #1 rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset
    repeat (20) @(negedge clk);
    chk("idle_reg", 8'(reg_ctrl), 8'h0);
    chk("idle_op", 8'(alu_op), 8'h0);
    chk("idle_valid", 8'(op_valid), 8'h0);

    // First enter: strobe 10 exactly two edges after first sampling high
    @(negedge clk);
    enter_i = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("strobeA_early", 8'(reg_ctrl), 8'h0);
    @(posedge clk); #1;
    chk("strobeA", 8'(reg_ctrl), 8'h2);
    @(posedge clk); #1;
    chk("strobeA_len", 8'(reg_ctrl), 8'h0);
    repeat (7) @(negedge clk);
    enter_i = 1'b0;
    repeat (6) @(negedge clk);

    // Sign toggle while loading B
    press_sign(3);
    chk("sign_loadB", 8'(signed_mode), 8'h1);
    chk("sign_loadB_valid", 8'(op_valid), 8'h0);

    // Second enter: load B then ADD
    press_enter(4);
    chk("opv_after_B", 8'(op_valid), 8'h1);
    chk("op_after_B", 8'(alu_op), 8'h0);

    op_seq[0] = 3'b001;
    op_seq[1] = 3'b010;
`ifdef ALU_CTRL_MUL_EN
    op_seq[2] = 3'b011;
    op_seq[3] = 3'b000;
`else
    op_seq[2] = 3'b000;
    op_seq[3] = 3'b001;
`endif
    for (int i = 0; i < NOPS; i++) begin
      press_enter(2);
      chk("op_cycle", 8'(alu_op), 8'(op_seq[i]));
      chk("op_cycle_reg", 8'(reg_ctrl), 8'h0);
    end

    press_sign(2);
    chk("sign_op1", 8'(signed_mode), 8'h0);
    press_sign(2);
    chk("sign_op2", 8'(signed_mode), 8'h1);
    chk("sign_op_alu", 8'(alu_op), 8'h0);

    // Simultaneous enter and sign rise in S_LOAD_A
    do_reset();
    repeat (2) @(negedge clk);
    enter_i = 1'b1;
    sign_i  = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("sim_sgn_early", 8'(signed_mode), 8'h0);
    @(posedge clk); #1;
    chk("sim_reg", 8'(reg_ctrl), 8'h2);
    chk("sim_sgn", 8'(signed_mode), 8'h1);
    @(negedge clk);
    enter_i = 1'b0;
    sign_i  = 1'b0;
    repeat (5) @(negedge clk);

    // Async reset during the load-B strobe
    @(negedge clk);
    enter_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (reg_ctrl == 2'b11) seen = 1'b1;
    end
    chk("strobeB_seen", 8'(seen), 8'h1);
    #2;
    enter_i = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_strobe_drop", 8'(reg_ctrl), 8'h0);
    chk("rst_sgn", 8'(signed_mode), 8'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", 8'(op_valid), 8'h0);
    chk("post_rst_op", 8'(alu_op), 8'h0);
    press_enter(3);
    chk("post_rst_loadB_valid", 8'(op_valid), 8'h0);

    // Random levels, including simultaneous edges and occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) enter_i = ~enter_i;
      if ($urandom_range(0, 7) == 0) sign_i = ~sign_i;
      if ($urandom_range(0, 3) == 0 && enter_i == sign_i) begin
        enter_i = 1'b1;
        sign_i  = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 4));
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
    end

    enter_i = 1'b0;
    sign_i  = 1'b0;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
